index_addsub_pipe: RTL and testbench

INDEX_ADDSUB_PIPE -- requirements
Module: index_addsub_pipe

---
 rtl/index_arith_pkg.sv | 22 ++
 rtl/index_addsub_stage.sv | 27 ++
 rtl/index_addsub_pipe.sv | 124 ++++++++++++
 tb/tb_index_addsub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/index_arith_pkg.sv
// Shared types for the index add/sub pipeline: operation encoding and the
// per-stage payload. Payload fields are sized for the widest supported
// configuration (WIDTH <= MAX_W, TAG_W <= MAX_TAG_W); users take the low bits.
package index_arith_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_TAG_W = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic [MAX_W-1:0]     s;
    logic                 carry;
    logic                 sat;
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
  } stage_t;

endpackage

// File: rtl/index_addsub_stage.sv
// One pipeline register stage: loads the payload when enabled, synchronous
// clear drops the valid and saturation flags (data/tag are left as-is).
module index_addsub_stage
  import index_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t q_q;

  // Payload register with sync clear of the flag bits only
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q.valid <= 1'b0;
      q_q.sat   <= 1'b0;
    end else if (en) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/index_addsub_pipe.sv
// Pipelined unsigned add/subtract with tag passthrough and valid/ready flow
// control. Arithmetic happens in front of stage 0; later stages only move the
// payload. Define INDEX_ADDSUB_SAT_EN to clamp add overflow to all-ones and
// sub underflow to zero (out_sat flags the clamped result); otherwise the
// result wraps and out_sat stays 0.
module index_addsub_pipe
  import index_arith_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic                           in_sub,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_s,
  output logic                           out_carry,
  output logic                           out_sat,
  output logic [TAG_W-1:0]               out_tag,
  output logic [$clog2(LATENCY+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(LATENCY+1);

  op_e              op;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res_d;
  logic             sat_d;
  stage_t           stage0_d;
  stage_t           stage_d [LATENCY];
  stage_t           stage_q [LATENCY];
  stage_t           last;
  logic             advance;
  logic             accept;
  logic             xfer;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             unused_bits;

  // Stage-0 arithmetic: A + B, or A + ~B + 1 for subtract, over WIDTH+1 bits
  always_comb begin
    op    = op_e'(in_sub);
    sum_d = {1'b0, in_a} + {1'b0, (op == OP_SUB) ? ~in_b : in_b}
          + {{WIDTH{1'b0}}, (op == OP_SUB)};
    res_d = sum_d[WIDTH-1:0];
    sat_d = 1'b0;
`ifdef INDEX_ADDSUB_SAT_EN
    if (op == OP_ADD && sum_d[WIDTH]) begin
      res_d = '1;
      sat_d = 1'b1;
    end else if (op == OP_SUB && !sum_d[WIDTH]) begin
      res_d = '0;
      sat_d = 1'b1;
    end
`endif
    stage0_d       = '0;
    stage0_d.s     = MAX_W'(res_d);
    stage0_d.carry = sum_d[WIDTH];
    stage0_d.sat   = sat_d;
    stage0_d.tag   = MAX_TAG_W'(in_tag);
    stage0_d.valid = in_valid;
  end

  // Stage inputs: new operation into stage 0, each later stage takes its predecessor
  always_comb begin
    stage_d[0] = stage0_d;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < LATENCY; g++) begin : g_stage
      index_addsub_stage u_stage (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .d_i (stage_d[g]),
        .q_o (stage_q[g])
      );
    end
  endgenerate

  assign last        = stage_q[LATENCY-1];
  assign out_valid   = last.valid;
  assign out_s       = last.s[WIDTH-1:0];
  assign out_carry   = last.carry;
  assign out_sat     = last.sat;
  assign out_tag     = last.tag[TAG_W-1:0];
  assign unused_bits = ^last;

  // Whole pipe moves together whenever the output slot is free or being taken
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign xfer     = out_valid && out_ready;

  // In-flight count: +1 on accept, -1 on output transfer
  always_comb begin
    occ_d = occ_q;
    case ({accept, xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy register with sync clear
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_index_addsub_pipe.sv
// Self-checking bench for index_addsub_pipe: scoreboard of expected results
// computed arithmetically, directed literal cases, throughput, stall, reset.
module tb_index_addsub_pipe;

  parameter int LATENCY = 2;
  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int OCC_W = $clog2(LATENCY+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_carry;
  logic             out_sat;
  logic [TAG_W-1:0] out_tag;
  logic [OCC_W-1:0] occupancy;

  index_addsub_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_carry(out_carry), .out_sat(out_sat), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   nout  = 0;
  int   dut_peak = 0;
  bit   chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic [TAG_W-1:0] tag);
    exp_t        e;
    int unsigned ai;
    int unsigned bi;
    int unsigned full;
    ai = a;
    bi = b;
    e.tag = tag;
    e.sat = 1'b0;
    if (!sub) begin
      full = ai + bi;
      e.c  = (full > 32'd65535);
      e.s  = 16'(full);
`ifdef INDEX_ADDSUB_SAT_EN
      if (e.c) begin e.s = 16'hFFFF; e.sat = 1'b1; end
`endif
    end else begin
      full = ai - bi;
      e.c  = (ai >= bi);
      e.s  = 16'(full);
`ifdef INDEX_ADDSUB_SAT_EN
      if (!e.c) begin e.s = 16'h0000; e.sat = 1'b1; end
`endif
    end
    return e;
  endfunction

  // Compare process: inputs change just after posedge, so the negedge sees the
  // exact values the next posedge will act on.
  logic             hold_pend = 0;
  logic [WIDTH-1:0] sv_s;
  logic             sv_c, sv_sat;
  logic [TAG_W-1:0] sv_tag;

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_s", 64'(out_s), 64'(sv_s));
        chk("hold_carry", 64'(out_carry), 64'(sv_c));
        chk("hold_sat", 64'(out_sat), 64'(sv_sat));
        chk("hold_tag", 64'(out_tag), 64'(sv_tag));
      end
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("occ_bound", 64'(int'(occupancy) <= LATENCY), 64'd1);
      if (int'(occupancy) > dut_peak) dut_peak = int'(occupancy);
      if (rst) begin
        q.delete();
        hold_pend = 0;
      end else begin
        if (out_valid && out_ready) begin
          chk("out_has_pending", 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_s", 64'(out_s), 64'(e.s));
            chk("out_carry", 64'(out_carry), 64'(e.c));
            chk("out_sat", 64'(out_sat), 64'(e.sat));
            chk("out_tag", 64'(out_tag), 64'(e.tag));
          end
          nout++;
        end
        hold_pend = out_valid && !out_ready;
        sv_s = out_s; sv_c = out_carry; sv_sat = out_sat; sv_tag = out_tag;
        if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub, in_tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h0001;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_ops();
    in_a   = pick();
    in_b   = pick();
    in_sub = 1'($urandom_range(0, 1));
    in_tag = 4'($urandom);
  endtask

  // Single operation into an empty pipe at out_ready=1; literal expectations
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [3:0] tag,
                          input logic [15:0] es, input logic ec, input logic esat);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_latency"}, 64'(n), 64'(LATENCY));
    chk({name, "_s"}, 64'(out_s), 64'(es));
    chk({name, "_carry"}, 64'(out_carry), 64'(ec));
    chk({name, "_sat"}, 64'(out_sat), 64'(esat));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    repeat (LATENCY + 2) step();
  endtask

  // N back-to-back ops at out_ready=1: results must appear L samples later, gap-free
  task automatic throughput(input int n_ops);
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n_ops + LATENCY + 3; i++) begin
      if (out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      in_valid = (i < n_ops);
      rand_ops();
      step();
    end
    in_valid = 1'b0;
    chk("tput_first", 64'(first), 64'(LATENCY));
    chk("tput_count", 64'(cnt), 64'(n_ops));
    chk("tput_nogap", 64'(last - first + 1), 64'(n_ops));
  endtask

  // 10 ops with a 3-cycle consumer stall once the pipe is full
  task automatic stall10();
    int sent, n0, stall_lo;
    bit fresh;
    sent = 0; n0 = nout; fresh = 1; dut_peak = 0;
    stall_lo = LATENCY + 2;
    for (int c = 0; c < 80 && (sent < 10 || nout - n0 < 10); c++) begin
      out_ready = !(c >= stall_lo && c <= stall_lo + 2);
      in_valid  = (sent < 10);
      if (fresh) rand_ops();
      #1;
      if (c >= stall_lo && c <= stall_lo + 2) chk("stall_in_ready", 64'(in_ready), 64'd0);
      fresh = in_valid && in_ready;
      if (fresh) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_all_out", 64'(nout - n0), 64'd10);
    chk("stall_occ_peak", 64'(dut_peak), 64'(LATENCY));
  endtask

  // Reset with operations in flight: nothing must emerge afterwards
  task automatic reset_mid();
    int pre;
    bit seen;
    pre = (LATENCY >= 2) ? 2 : 1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_ops(); step();
    rand_ops(); step();
    in_valid = 1'b0;
    chk("rstmid_pre_occ", 64'(occupancy), 64'(pre));
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_occ", 64'(occupancy), 64'd0);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (LATENCY + 3) begin
      if (out_valid) seen = 1;
      step();
    end
    chk("rstmid_no_result", 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    chk_en = 1;
    out_ready = 1'b1;
    step(); step();

    directed("add_basic", 16'h1234, 16'h0FFF, 1'b0, 4'd3, 16'h2233, 1'b0, 1'b0);
`ifdef INDEX_ADDSUB_SAT_EN
    directed("add_ovf", 16'hFFFF, 16'h0001, 1'b0, 4'd5, 16'hFFFF, 1'b1, 1'b1);
    directed("sub_unf", 16'h0005, 16'h0007, 1'b1, 4'd9, 16'h0000, 1'b0, 1'b1);
`else
    directed("add_ovf", 16'hFFFF, 16'h0001, 1'b0, 4'd5, 16'h0000, 1'b1, 1'b0);
    directed("sub_unf", 16'h0005, 16'h0007, 1'b1, 4'd9, 16'hFFFE, 1'b0, 1'b0);
`endif
    directed("sub_eq", 16'h4321, 16'h4321, 1'b1, 4'd12, 16'h0000, 1'b1, 1'b0);

    throughput(20);
    repeat (2) step();
    stall10();
    repeat (2) step();
    reset_mid();

    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      rand_ops();
      step();
    end

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LATENCY + 3) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
